line_link_rx: RTL and testbench



---
 rtl/line_link_rx.sv | 140 ++++++++++++++
 tb/tb_line_link_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/line_link_rx.sv
// line_link_rx: deserialises 7-bit line-count frames and emits spaced single-line add pulses
module line_link_rx #(
  parameter int BIT_CYCLES = 250,
  parameter int PULSE_LEN  = 1000,
  parameter int GAP_LEN    = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       link_rx_i,
  output logic       add_line_o,
  output logic [3:0] pending_o,
  output logic       frame_err_o,
  output logic       rx_busy_o
);
  localparam int TW   = $clog2(BIT_CYCLES);
  localparam int EMAX = PULSE_LEN > GAP_LEN ? PULSE_LEN : GAP_LEN;
  localparam int EW   = $clog2(EMAX + 1);
  localparam logic [TW-1:0] HALF   = TW'(BIT_CYCLES / 2 - 1);
  localparam logic [TW-1:0] FULL   = TW'(BIT_CYCLES - 1);
  localparam logic [EW-1:0] P_LAST = EW'(PULSE_LEN - 1);
  localparam logic [EW-1:0] G_LAST = EW'(GAP_LEN - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_t;
  typedef enum logic [1:0] {EIDLE, PULSE, GAP} em_t;
  logic [1:0]    sync_q;
  logic          prev_q;
  rx_t           rx_q, rx_d;
  logic [TW-1:0] tim_q, tim_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic          done_q, done_d;
  logic          ok_q, ok_d;
  logic [3:0]    pend_q, pend_d;
  logic          ferr_q, ferr_d;
  em_t           em_q, em_d;
  logic [EW-1:0] etim_q, etim_d;
  logic          add_q, add_d;
  logic          s, tick, dec;
  logic [4:0]    sum;
  assign s    = sync_q[1];
  assign tick = tim_q == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      rx_q   <= IDLE;
      tim_q  <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      pend_q <= '0;
      ferr_q <= 1'b0;
      em_q   <= EIDLE;
      etim_q <= '0;
      add_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], link_rx_i};
      prev_q <= s;
      rx_q   <= rx_d;
      tim_q  <= tim_d;
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      par_q  <= par_d;
      done_q <= done_d;
      ok_q   <= ok_d;
      pend_q <= pend_d;
      ferr_q <= ferr_d;
      em_q   <= em_d;
      etim_q <= etim_d;
      add_q  <= add_d;
    end
  end
  always_comb begin
    rx_d   = rx_q;
    tim_d  = tick ? '0 : tim_q - 1'b1;
    idx_d  = idx_q;
    sh_d   = sh_q;
    par_d  = par_q;
    done_d = 1'b0;
    ok_d   = ok_q;
    case (rx_q)
      IDLE:      if (prev_q && !s) begin
        rx_d  = START;
        tim_d = HALF;
      end
      START:     if (tick) begin
        rx_d  = s ? IDLE : DATA;
        tim_d = FULL;
        idx_d = '0;
      end
      DATA:      if (tick) begin
        sh_d  = {s, sh_q[3:1]};
        idx_d = idx_q + 1'b1;
        tim_d = FULL;
        rx_d  = idx_q == 2'd3 ? PARITY : DATA;
      end
      PARITY:    if (tick) begin
        par_d = s;
        tim_d = FULL;
        rx_d  = STOP;
      end
      STOP:      if (tick) begin
        done_d = 1'b1;
        ok_d   = s && !(^{sh_q, par_q});
        rx_d   = s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: rx_d = s ? IDLE : WAIT_HIGH;
      default:   rx_d = IDLE;
    endcase
  end
  // sh_q stays stable through the cycle after STOP, so the count is read here
  assign sum    = {1'b0, pend_q} + (done_q && ok_q ? {1'b0, sh_q} : 5'd0) - {4'd0, dec};
  assign pend_d = sum > 5'd15 ? 4'd15 : sum[3:0];
  assign ferr_d = done_q && !ok_q;
  always_comb begin
    em_d   = em_q;
    etim_d = etim_q == '0 ? '0 : etim_q - 1'b1;
    dec    = 1'b0;
    case (em_q)
      EIDLE:   if (pend_q != '0) begin
        em_d   = PULSE;
        etim_d = P_LAST;
        dec    = 1'b1;
      end
      PULSE:   if (etim_q == '0) begin
        em_d   = GAP;
        etim_d = G_LAST;
      end
      GAP:     em_d = etim_q == '0 ? EIDLE : GAP;
      default: em_d = EIDLE;
    endcase
  end
  assign add_d       = em_d == PULSE;
  assign add_line_o  = add_q;
  assign pending_o   = pend_q;
  assign frame_err_o = ferr_q;
  assign rx_busy_o   = rx_q != IDLE;
endmodule

// File: tb/tb_line_link_rx.sv
// tb_line_link_rx: scoreboard bench for line_link_rx
module tb_line_link_rx;
  typedef struct packed {logic err; logic [3:0] cnt;} exp_t;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       link_rx;
  logic       add_line;
  logic [3:0] pending;
  logic       frame_err;
  logic       rx_busy;
  int checks = 0, failures = 0;
  int cyc = 0, pulses = 0, ferr_cnt = 0, busy_cnt = 0, maxp = 0, acc_cyc = 0, hi_len = 0;
  int rises[$];
  exp_t sb[$];
  logic [3:0] prev_pend = '0;
  logic prev_add = 1'b0;
  line_link_rx #(.BIT_CYCLES(8), .PULSE_LEN(4), .GAP_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .link_rx_i(link_rx), .add_line_o(add_line),
    .pending_o(pending), .frame_err_o(frame_err), .rx_busy_o(rx_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    int delta, ep;
    bit rose;
    if (!rst_n) begin
      prev_pend = '0;
      prev_add  = 1'b0;
      hi_len    = 0;
    end else begin
      rose = add_line && !prev_add;
      if (rose) begin
        pulses++;
        rises.push_back(cyc);
      end
      if (add_line) hi_len++;
      else if (prev_add) begin
        check("pulse_width", hi_len, 4);
        hi_len = 0;
      end
      if (rx_busy) busy_cnt++;
      if (int'(pending) > maxp) maxp = int'(pending);
      delta = int'(pending) - int'(prev_pend) + (rose ? 1 : 0);
      if (frame_err) begin
        ferr_cnt++;
        if (sb.size() == 0) check("unexpected_err", 1, 0);
        else begin
          e = sb.pop_front();
          check("err_kind", 1, int'(e.err));
          check("err_pend", int'(pending), int'(prev_pend) - (rose ? 1 : 0));
        end
      end else if (delta != 0) begin
        acc_cyc = cyc;
        if (sb.size() == 0) check("unexpected_acc", 1, 0);
        else begin
          e = sb.pop_front();
          ep = int'(prev_pend) + int'(e.cnt) - (rose ? 1 : 0);
          check("acc_kind", 0, int'(e.err));
          check("acc_pend", int'(pending), ep > 15 ? 15 : ep);
        end
      end
      prev_pend = pending;
      prev_add  = add_line;
    end
  end
  task automatic drive_bit(input logic v, input int n);
    link_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [3:0] c, input bit flip_par, input logic stop);
    logic [6:0] b;
    b = {stop, (^c) ^ flip_par, c, 1'b0};
    for (int i = 0; i < 7; i++) drive_bit(b[i], 8);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((pending != 0 || add_line) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", int'(n < 2000), 1);
    repeat (8) @(posedge clk);
    #1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int p0, f0, r0, b0, n;
    rst_n = 1'b0;
    link_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_add", int'(add_line), 0);
    check("rst_pend", int'(pending), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_busy", int'(rx_busy), 0);
    @(posedge clk);
    #1;
    p0 = pulses; f0 = ferr_cnt; r0 = rises.size();
    sb.push_back('{err: 1'b0, cnt: 4'd3});
    send_frame(4'd3, 1'b0, 1'b1);
    drain();
    check("c3_pulses", pulses - p0, 3);
    if (rises.size() >= r0 + 3) begin
      check("c3_latency", rises[r0] - acc_cyc, 1);
      check("c3_period1", rises[r0+1] - rises[r0], 9);
      check("c3_period2", rises[r0+2] - rises[r0+1], 9);
    end
    check("c3_pend", int'(pending), 0);
    check("c3_ferr", ferr_cnt - f0, 0);
    p0 = pulses; f0 = ferr_cnt;
    sb.push_back('{err: 1'b1, cnt: 4'd0});
    send_frame(4'd5, 1'b1, 1'b1);
    drive_bit(1'b1, 12);
    check("par_pulses", pulses - p0, 0);
    check("par_ferr", ferr_cnt - f0, 1);
    check("par_pend", int'(pending), 0);
    f0 = ferr_cnt; b0 = busy_cnt;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 20);
    check("glitch_busy", int'(busy_cnt - b0 > 0 && busy_cnt - b0 < 8), 1);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_pend", int'(pending), 0);
    p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{err: 1'b0, cnt: 4'd10});
      send_frame(4'd10, 1'b0, 1'b1);
    end
    drain();
    check("clamp_pulses", pulses - p0, 28);
    check("clamp_max", maxp, 15);
    f0 = ferr_cnt;
    sb.push_back('{err: 1'b1, cnt: 4'd0});
    send_frame(4'd6, 1'b0, 1'b0);
    drive_bit(1'b0, 30);
    check("stuck_busy", int'(rx_busy), 1);
    check("stuck_ferr", ferr_cnt - f0, 1);
    drive_bit(1'b1, 16);
    check("stuck_release", int'(rx_busy), 0);
    p0 = pulses;
    sb.push_back('{err: 1'b0, cnt: 4'd1});
    send_frame(4'd1, 1'b0, 1'b1);
    drain();
    check("after_stuck_pulses", pulses - p0, 1);
    check("after_stuck_ferr", ferr_cnt - f0, 1);
    sb.push_back('{err: 1'b0, cnt: 4'd6});
    send_frame(4'd6, 1'b0, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(add_line && pending == 4'd5) && n < 500);
    check("rst_wait", int'(n < 500), 1);
    @(posedge clk);
    #1;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b1, 4);
    check("pre_rst_pend", int'(pending), 2);
    check("pre_rst_add", int'(add_line), 1);
    check("pre_rst_busy", int'(rx_busy), 1);
    rst_n = 1'b0;
    #1;
    check("arst_add", int'(add_line), 0);
    check("arst_pend", int'(pending), 0);
    check("arst_ferr", int'(frame_err), 0);
    check("arst_busy", int'(rx_busy), 0);
    link_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    p0 = pulses;
    sb.push_back('{err: 1'b0, cnt: 4'd1});
    send_frame(4'd1, 1'b0, 1'b1);
    drain();
    check("post_rst_pulses", pulses - p0, 1);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
